// File: rtl/prog_instr_mem_pkg.sv
// Shared types and helpers for the program instruction memory.
// Optional feature macro: PROG_INSTR_MEM_PARITY_EN (per-word even parity).
package prog_instr_mem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Widest instruction word the helpers below can cover.
  localparam int MAX_INSTR_W = 256;

  // HALT instruction: all-ones. Callers slice it down to their word width.
  localparam logic [MAX_INSTR_W-1:0] HALT_WORD = '1;

  // Even-parity bit: makes the total count of ones, parity bit included, even.
  function automatic logic even_par(input logic [MAX_INSTR_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/prog_instr_mem_imem_array.sv
// Word storage: synchronous write port and registered read port.
// Content is preset to INIT at power-up and is never touched by reset;
// only the read register is reset.
module imem_array #(
  parameter int             W      = 16,
  parameter int             DEPTH  = 32,
  parameter int             ADDR_W = 5,
  parameter logic [W-1:0]   INIT   = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [W-1:0]      wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [W-1:0]      rd_data_o
);

  logic [W-1:0] mem [DEPTH] = '{default: INIT};
  logic [W-1:0] rd_q;

  // Write port: one word per cycle.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Read register: only updates on an in-range read, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n)       rd_q <= '0;
    else if (rd_en_i) rd_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/prog_instr_mem.sv
// Program instruction memory: streams a program in (LOAD), then serves
// one-cycle-latency fetches (RUN) until reset.
// Optional feature macro: PROG_INSTR_MEM_PARITY_EN adds a stored even-parity
// bit per word and reports mismatches on fetch_err.
module prog_instr_mem
  import prog_instr_mem_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_valid,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               prog_last,
  output logic               prog_ready,
  output logic               prog_done,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] fetch_data,
  output logic               fetch_err,
  output logic               running
);

`ifdef PROG_INSTR_MEM_PARITY_EN
  localparam int PAR_W = 1;
  // Unwritten words must read back as HALT with consistent parity.
  localparam logic [INSTR_W:0] MEM_INIT =
    {((INSTR_W % 2) != 0), HALT_WORD[INSTR_W-1:0]};
`else
  localparam int PAR_W = 0;
  localparam logic [INSTR_W-1:0] MEM_INIT = HALT_WORD[INSTR_W-1:0];
`endif
  localparam int MEM_W = INSTR_W + PAR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wp_q, wp_d;
  logic                done_q, fv_q, oor_q;
  logic                accept, last_acc, fire, oor, wr_en, rd_en, par_err;
  logic [MEM_W-1:0]    wr_word, rd_word;

  assign accept   = prog_ready & prog_valid;
  assign last_acc = accept & (prog_last | (wp_q == ADDR_W'(DEPTH - 1)));
  assign fire     = fetch_req & (state_q == RUN);
  assign oor      = {1'b0, fetch_addr} >= (ADDR_W + 1)'(DEPTH);
  // A word offered in the reset cycle must not land in memory.
  assign wr_en    = accept & rst_n;
  // Out-of-range reads never index the array; the HALT word is muxed instead.
  assign rd_en    = fire & ~oor;
  assign wp_d     = accept ? wp_q + ADDR_W'(1) : wp_q;

`ifdef PROG_INSTR_MEM_PARITY_EN
  assign wr_word = {even_par(MAX_INSTR_W'(prog_data)), prog_data};
  assign par_err = ^rd_word;
`else
  assign wr_word = prog_data;
  assign par_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // FSM next state: RUN is sticky until reset.
  always_comb begin
    state_d = state_q;
    if (state_q == LOAD && last_acc) state_d = RUN;
  end

  // FSM outputs.
  always_comb begin
    prog_ready = (state_q == LOAD);
    running    = (state_q == RUN);
  end

  // Load pointer, done pulse, fetch valid and range-error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q   <= '0;
      done_q <= 1'b0;
      fv_q   <= 1'b0;
      oor_q  <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      done_q <= last_acc;
      fv_q   <= fire;
      if (fire) oor_q <= oor;
    end
  end

  imem_array #(
    .W      (MEM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INIT   (MEM_INIT)
  ) u_arr (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wp_q),
    .wr_data_i (wr_word),
    .rd_en_i   (rd_en),
    .rd_addr_i (fetch_addr),
    .rd_data_o (rd_word)
  );

  assign prog_done   = done_q;
  assign fetch_valid = fv_q;
  // Both sources are registered, so data and error hold between fetches.
  assign fetch_data  = oor_q ? HALT_WORD[INSTR_W-1:0] : rd_word[INSTR_W-1:0];
  assign fetch_err   = oor_q | par_err;

endmodule

// File: tb/tb_prog_instr_mem.sv
// Bench for prog_instr_mem: a DEPTH=32 instance for load/fetch behaviour and
// a DEPTH=20 instance for out-of-range fetches. Fetch results go through
// per-instance expectation queues checked by negedge monitors.
module tb_prog_instr_mem;

  typedef struct {
    logic [15:0] d;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  exp_t qa[$];
  exp_t qb[$];

  // Instance A (DEPTH=32)
  logic        rst_n, prog_valid, prog_last, fetch_req;
  logic [15:0] prog_data;
  logic [4:0]  fetch_addr;
  logic        prog_ready, prog_done, fetch_valid, fetch_err, running;
  logic [15:0] fetch_data;

  // Instance B (DEPTH=20)
  logic        rst_n_b, prog_valid_b, prog_last_b, fetch_req_b;
  logic [15:0] prog_data_b;
  logic [4:0]  fetch_addr_b;
  logic        prog_ready_b, prog_done_b, fetch_valid_b, fetch_err_b, running_b;
  logic [15:0] fetch_data_b;

  prog_instr_mem #(.INSTR_W(16), .DEPTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_last(prog_last), .prog_ready(prog_ready), .prog_done(prog_done),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data), .fetch_err(fetch_err), .running(running)
  );

  prog_instr_mem #(.INSTR_W(16), .DEPTH(20)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .prog_valid(prog_valid_b), .prog_data(prog_data_b),
    .prog_last(prog_last_b), .prog_ready(prog_ready_b), .prog_done(prog_done_b),
    .fetch_req(fetch_req_b), .fetch_addr(fetch_addr_b), .fetch_valid(fetch_valid_b),
    .fetch_data(fetch_data_b), .fetch_err(fetch_err_b), .running(running_b)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] d, input logic last);
    prog_valid = 1'b1; prog_data = d; prog_last = last;
    tick();
    prog_valid = 1'b0; prog_last = 1'b0;
  endtask

  task automatic fetch(input logic [4:0] a, input logic [15:0] d, input logic e);
    exp_t x;
    x.d = d; x.e = e;
    qa.push_back(x);
    fetch_req = 1'b1; fetch_addr = a;
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic fetch_b(input logic [4:0] a, input logic [15:0] d, input logic e);
    exp_t x;
    x.d = d; x.e = e;
    qb.push_back(x);
    fetch_req_b = 1'b1; fetch_addr_b = a;
    tick();
    fetch_req_b = 1'b0;
  endtask

  // Monitor A: every fetch_valid must match the oldest expectation.
  always @(negedge clk) begin
    exp_t ea;
    if (fetch_valid === 1'b1) begin
      n_vec++;
      if (qa.size() == 0) begin
        n_err++;
        $display("FAIL mon_a: unexpected fetch_valid data=%h err=%b", fetch_data, fetch_err);
      end else begin
        ea = qa.pop_front();
        if (fetch_data !== ea.d || fetch_err !== ea.e) begin
          n_err++;
          $display("FAIL mon_a: got data=%h err=%b expected data=%h err=%b",
                   fetch_data, fetch_err, ea.d, ea.e);
        end
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    exp_t eb;
    if (fetch_valid_b === 1'b1) begin
      n_vec++;
      if (qb.size() == 0) begin
        n_err++;
        $display("FAIL mon_b: unexpected fetch_valid data=%h err=%b", fetch_data_b, fetch_err_b);
      end else begin
        eb = qb.pop_front();
        if (fetch_data_b !== eb.d || fetch_err_b !== eb.e) begin
          n_err++;
          $display("FAIL mon_b: got data=%h err=%b expected data=%h err=%b",
                   fetch_data_b, fetch_err_b, eb.d, eb.e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; prog_valid = 1'b0; prog_data = '0; prog_last = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    rst_n_b = 1'b0; prog_valid_b = 1'b0; prog_data_b = '0; prog_last_b = 1'b0;
    fetch_req_b = 1'b0; fetch_addr_b = '0;
    tick(); tick();

    // Reset state
    chk("rst_done",  prog_done,   0);
    chk("rst_valid", fetch_valid, 0);
    chk("rst_err",   fetch_err,   0);
    chk("rst_run",   running,     0);
    chk("rst_data",  fetch_data,  0);
    rst_n = 1'b1;
    tick();
    chk("load_ready", prog_ready, 1);

    // Fetch during LOAD is dropped
    fetch_req = 1'b1; fetch_addr = 5'd0;
    tick();
    fetch_req = 1'b0;
    chk("load_fetch_drop", fetch_valid, 0);

    // Three-word program, last flag on the third
    load(16'h3004, 1'b0);
    chk("done_early", prog_done, 0);
    load(16'h3105, 1'b0);
    load(16'h5F84, 1'b1);
    chk("done_pulse", prog_done, 1);
    chk("run_entered", running, 1);
    chk("run_ready", prog_ready, 0);
    tick();
    chk("done_once", prog_done, 0);
    fetch(5'd2, 16'h5F84, 1'b0);
    // Back-to-back fetches
    fetch(5'd0, 16'h3004, 1'b0);
    fetch(5'd1, 16'h3105, 1'b0);
    fetch(5'd2, 16'h5F84, 1'b0);
    tick();
    chk("idle_valid", fetch_valid, 0);
    chk("idle_hold", fetch_data, 16'h5F84);

    // Reset after 3 of 5 words; word offered during reset must be dropped
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    load(16'h1111, 1'b0);
    load(16'h2222, 1'b0);
    load(16'h3333, 1'b0);
    rst_n = 1'b0; prog_valid = 1'b1; prog_data = 16'hBEEF;
    tick();
    prog_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_ready", prog_ready, 1);
    load(16'hAAAA, 1'b1);
    chk("reload_done", prog_done, 1);
    fetch(5'd0, 16'hAAAA, 1'b0);
    fetch(5'd1, 16'h2222, 1'b0);
    fetch(5'd2, 16'h3333, 1'b0);
    fetch(5'd3, 16'hFFFF, 1'b0);
    fetch(5'd4, 16'hFFFF, 1'b0);

    // Full 32-word load, no last flag
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      load(16'h1000 + 16'(i), 1'b0);
      if (i == 30) chk("full_not_yet", running, 0);
      if (i == 31) begin
        chk("full_run", running, 1);
        chk("full_done", prog_done, 1);
      end
    end
    // prog_valid in RUN is ignored (pointer would otherwise wrap onto addr 0)
    prog_valid = 1'b1; prog_data = 16'hDEAD;
    tick();
    prog_valid = 1'b0;
    chk("run_no_ready", prog_ready, 0);
    fetch(5'd0,  16'h1000, 1'b0);
    fetch(5'd31, 16'h101F, 1'b0);
    fetch(5'd17, 16'h1011, 1'b0);
    tick();
    chk("full_idle_valid", fetch_valid, 0);
    chk("full_idle_hold", fetch_data, 16'h1011);

`ifdef PROG_INSTR_MEM_PARITY_EN
    // Corrupt one stored bit of addr 1 (0x1001 -> 0x1000)
    u_dut.u_arr.mem[1][0] = ~u_dut.u_arr.mem[1][0];
    fetch(5'd1, 16'h1000, 1'b1);
    fetch(5'd2, 16'h1002, 1'b0);
`endif

    // Instance B: range errors at and beyond DEPTH=20
    tick();
    rst_n_b = 1'b1;
    prog_valid_b = 1'b1; prog_data_b = 16'h0042; prog_last_b = 1'b1;
    tick();
    prog_valid_b = 1'b0; prog_last_b = 1'b0;
    chk("b_run", running_b, 1);
    fetch_b(5'd25, 16'hFFFF, 1'b1);
    fetch_b(5'd0,  16'h0042, 1'b0);
    fetch_b(5'd19, 16'hFFFF, 1'b0);
    fetch_b(5'd20, 16'hFFFF, 1'b1);
    fetch_b(5'd31, 16'hFFFF, 1'b1);
    tick();
    chk("b_idle_hold", fetch_data_b, 16'hFFFF);
    chk("b_idle_err", fetch_err_b, 1);

    tick(); tick();
    chk("qa_drain", qa.size(), 0);
    chk("qb_drain", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
